// File: rtl/serial_full_adder.sv
// Bit-serial adder: one full-adder cell and a carry flip-flop add two WIDTH-bit
// operands plus carry-in, LSB first, one bit per clock, with start/busy/done.
module serial_full_adder #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   a_sh, a_sh_d;
  logic [WIDTH-1:0]   b_sh, b_sh_d;
  logic [WIDTH-1:0]   acc, acc_d;
  logic [WIDTH-1:0]   sum_d;
  logic               c, c_d;
  logic               cout_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               s;
  logic               c_next;

  // Handshake: start is taken on any edge where the block is in IDLE or DONE;
  // busy marks the WIDTH shifting cycles, done pulses once when sum/cout update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_d;
      a_sh  <= a_sh_d;
      b_sh  <= b_sh_d;
      acc   <= acc_d;
      c     <= c_d;
      cnt   <= cnt_d;
      sum   <= sum_d;
      cout  <= cout_d;
    end
  end

  always_comb begin
    state_d = state;
    a_sh_d  = a_sh;
    b_sh_d  = b_sh;
    acc_d   = acc;
    c_d     = c;
    cnt_d   = cnt;
    sum_d   = sum;
    cout_d  = cout;
    s       = a_sh[0] ^ b_sh[0] ^ c;
    c_next  = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]));
    case (state)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          acc_d   = '0;
          c_d     = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sh_d  = a_sh >> 1;
        b_sh_d  = b_sh >> 1;
        // Sum bits enter at the MSB so the LSB-first result lands aligned.
        acc_d   = acc >> 1;
        acc_d[WIDTH-1] = s;
        c_d     = c_next;
        cnt_d   = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          sum_d   = acc_d;
          cout_d  = c_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_full_adder.sv
// Directed bench for serial_full_adder: an 8-bit instance for the main
// scenarios and a 1-bit instance for the exhaustive full-adder sweep.
module tb_serial_full_adder;

  logic       clk;
  logic       rst_n;
  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start1;
  logic [0:0] a1, b1;
  logic       cin1;
  logic       busy1, done1;
  logic [0:0] sum1;
  logic       cout1;

  int checks;
  int errors;

  serial_full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one 8-bit operation from a sample point; checks busy window, done
  // pulse, held result during SHIFT and the final result.
  task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb,
                         input logic tcin, input logic [7:0] exp_sum,
                         input logic exp_cout, input string name);
    logic [7:0] prev_sum;
    logic       prev_cout;
    prev_sum  = sum8;
    prev_cout = cout8;
    a8 = ta; b8 = tb; cin8 = tcin; start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0) begin
        errors++;
        $display("FAIL %s shift cycle %0d: busy=%b done=%b, required busy=1 done=0", name, i, busy8, done8);
      end
      checks++;
      if (sum8 !== prev_sum || cout8 !== prev_cout) begin
        errors++;
        $display("FAIL %s held result cycle %0d: sum=%h cout=%b, required sum=%h cout=%b", name, i, sum8, cout8, prev_sum, prev_cout);
      end
      step();
    end
    checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL %s done cycle: busy=%b done=%b, required busy=0 done=1", name, busy8, done8);
    end
    checks++;
    if (sum8 !== exp_sum || cout8 !== exp_cout) begin
      errors++;
      $display("FAIL %s result: sum=%h cout=%b, required sum=%h cout=%b", name, sum8, cout8, exp_sum, exp_cout);
    end
    step();
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL %s after done: busy=%b done=%b, required busy=0 done=0", name, busy8, done8);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) step();
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      errors++;
      $display("FAIL reset8: busy=%b done=%b sum=%h cout=%b, required all zero", busy8, done8, sum8, cout8);
    end
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || sum1 !== 1'b0 || cout1 !== 1'b0) begin
      errors++;
      $display("FAIL reset1: busy=%b done=%b sum=%b cout=%b, required all zero", busy1, done1, sum1, cout1);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    run_op8(8'h03, 8'h05, 1'b0, 8'h08, 1'b0, "add_03_05");
    run_op8(8'h5A, 8'h25, 1'b1, 8'h80, 1'b0, "add_5a_25_c1");
  endtask

  task automatic test_overflow();
    run_op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ovf_ff_01");
    run_op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ovf_ff_ff_c1");
    run_op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "ovf_80_80");
  endtask

  task automatic test_width1();
    // {sum,cout} for inputs {a,b,cin} = 000..111
    logic [1:0] tbl [8];
    logic [2:0] idx;
    tbl = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      a1 = idx[2]; b1 = idx[1]; cin1 = idx[0]; start1 = 1'b1;
      step();
      start1 = 1'b0;
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        errors++;
        $display("FAIL w1 shift %0d: busy=%b done=%b, required busy=1 done=0", i, busy1, done1);
      end
      step();
      checks++;
      if (done1 !== 1'b1 || {sum1, cout1} !== tbl[i]) begin
        errors++;
        $display("FAIL w1 result %0d: done=%b sum=%b cout=%b, required done=1 sum,cout=%b", i, done1, sum1, cout1, tbl[i]);
      end
      repeat (8) step();
    end
  endtask

  task automatic test_ignore_start();
    int n_done;
    n_done = 0;
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      if (done8 === 1'b1) begin
        n_done++;
        checks++;
        if (i != 8 || sum8 !== 8'h30 || cout8 !== 1'b0) begin
          errors++;
          $display("FAIL ignore_start result: at %0d sum=%h cout=%b, required at 8 sum=30 cout=0", i, sum8, cout8);
        end
      end
      step();
    end
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL ignore_start done count: %0d, required 1", n_done);
    end
  endtask

  task automatic test_reset_mid();
    int n_done;
    n_done = 0;
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b, required all zero", busy8, done8, sum8, cout8);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (done8 === 1'b1 || busy8 === 1'b1) n_done++;
      step();
    end
    checks++;
    if (n_done != 0) begin
      errors++;
      $display("FAIL reset_mid activity after reset: %0d cycles, required 0", n_done);
    end
    run_op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b1; start8 = 1'b1;
    step();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
          errors++;
          $display("FAIL b2b run %0d shift %0d: busy=%b done=%b, required busy=1 done=0", r, i, busy8, done8);
        end
        step();
      end
      checks++;
      if (done8 !== 1'b1 || busy8 !== 1'b0 || sum8 !== 8'h03 || cout8 !== 1'b0) begin
        errors++;
        $display("FAIL b2b run %0d done: busy=%b done=%b sum=%h cout=%b, required busy=0 done=1 sum=03 cout=0", r, busy8, done8, sum8, cout8);
      end
      step();
    end
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("FAIL b2b restart: busy=%b, required 1", busy8);
    end
    repeat (12) step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_width1();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_full_adder.md
Name: serial_full_adder

Overview:
Bit-serial adder: the addition counterpart of the team's full subtractor cell, built around one full-adder cell plus a carry flip-flop. Adds two WIDTH-bit operands and a carry-in LSB-first, one bit per clock. Uses a start/busy/done handshake. Intended as the area-cheap arithmetic unit for the sequential datapath assignments, and as the reference model pairing for the subtractor work.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden by users)

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      asynchronous active-low reset
start  input   1      request; operands sampled on the clk edge where start=1 and the block is accepting
a      input   WIDTH  operand A
b      input   WIDTH  operand B
cin    input   1      carry-in
busy   output  1      1 while the serial addition is in progress
done   output  1      one-cycle pulse; sum/cout valid from this cycle on
sum    output  WIDTH  result register (A+B+cin)[WIDTH-1:0]
cout   output  1      result carry-out (A+B+cin)[WIDTH]

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - internal shift regs, carry FF and counter cleared.
  - An operation in flight is abandoned; no done is produced for it.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- Accepting = state IDLE or DONE.
- IDLE:
  - start=1 -> latch a, b into shift regs; carry FF=cin; count=0; go to SHIFT.
  - start=0 -> stay in IDLE.
- SHIFT (busy=1), each cycle:
  - s = a_sh[0]^b_sh[0]^c; c_next = a_sh[0]&b_sh[0] | c&(a_sh[0]^b_sh[0]).
  - Shift a_sh and b_sh right by 1. Shift the internal accumulator right, inserting s at the MSB. c<=c_next; count++.
  - When count reaches WIDTH-1 (the last bit in this cycle), go to DONE.
- DONE (one cycle):
  - busy=0, done=1.
  - sum<=final accumulator and cout<=final carry, loaded on the SHIFT->DONE edge.
  - start=1 in DONE -> new operation accepted exactly as from IDLE (back-to-back, no bubble), next state SHIFT. Otherwise next state IDLE.
- Latency: start sampled at edge k -> busy=1 for cycles k+1..k+WIDTH, done=1 at cycle k+WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- sum/cout change only on the SHIFT->DONE edge. They hold the last result through IDLE and through subsequent SHIFT phases.
- start while busy=1 is ignored: no latch, no state effect, no queuing. a/b/cin changes during SHIFT have no effect.
- Arithmetic is unsigned modulo 2^WIDTH; overflow is reported only via cout.
- WIDTH=1 degenerates to a registered full adder: one SHIFT cycle, then DONE.

Test Plan:
- WIDTH=8, start with a=0x03, b=0x05, cin=0 -> busy high 8 cycles; done pulse at cycle 9 after start; sum=0x08, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- WIDTH=1, sweep all 8 (a,b,cin) combos at 100-time-unit spacing -> (sum,cout) = 00,10,10,01,10,01,01,11 for inputs 000..111; done after each.
- Start a=0x10,b=0x20; pulse start with a=0xAA,b=0x55 at cycle 3 of SHIFT -> ignored; result sum=0x30, cout=0; done only once.
- Start a=0x7F,b=0x01; assert rst_n=0 at cycle 4 of SHIFT -> immediately busy=0, done=0, sum=0x00, cout=0; no done pulse afterwards. New start after release gives a correct result.
- Hold start=1 continuously with a=0x01,b=0x01,cin=1 -> done pulses every 9 cycles, sum=0x03 each time, busy deasserted only during the DONE cycles.
